// File: rtl/bram_arbiter_pkg.sv
// Shared types and defaults for the BRAM arbiter slice.
// The optional BRAM_ARB_LOCK_EN build adds the lock-state enum use in bram_arbiter.
package bram_arb_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_AW      = 10;
    localparam int DEF_DEPTH   = 801;
    localparam int DEF_DW      = 32;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;
    localparam int         BYTE_SHIFT = 2;
    localparam int         ID_W       = 3;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_rd;
        logic            err;
    } tag_t;

    typedef enum logic {
        LK_IDLE,
        LK_HELD
    } lock_state_e;

    function automatic logic [31:0] word_to_byte(input logic [31:0] word);
        return word << BYTE_SHIFT;
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester and BRAM-side signal bundle for bram_arbiter.
// With BRAM_ARB_LOCK_EN defined the bundle also carries the per-requester lock.
interface bram_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [DW-1:0]         rd_data;
    logic [NUM_REQ-1:0]    addr_err;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [31:0]           mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;
`ifdef BRAM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    lock;
`endif

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rd_valid, rd_data, addr_err, mem_en, mem_we, mem_addr, mem_wdata
`ifdef BRAM_ARB_LOCK_EN
        , input lock
`endif
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rd_valid, rd_data, addr_err, mem_en, mem_we, mem_addr, mem_wdata
`ifdef BRAM_ARB_LOCK_EN
        , output lock
`endif
    );

endinterface

// File: rtl/bram_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any,
    output logic [PW-1:0] o_next_ptr
);
    int unsigned   w_c;
    logic [PW-1:0] w_cidx;

    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        o_any      = 1'b0;
        o_next_ptr = i_ptr;
        w_c        = 0;
        w_cidx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_c = 32'(i_ptr) + k;
            if (w_c >= N) w_c = w_c - N;
            w_cidx = PW'(w_c);
            if (!o_any && i_req[w_cidx]) begin
                o_any         = 1'b1;
                o_gnt[w_cidx] = 1'b1;
                o_idx         = w_cidx;
                o_next_ptr    = (w_c == N - 1) ? '0 : PW'(w_c + 1);
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ engines.
// Define BRAM_ARB_LOCK_EN to let a granted requester hold the BRAM via bus.lock.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int AW      = DEF_AW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DW      = DEF_DW
) (
    input logic           clk,
    input logic           rst,
    bram_arbiter_if.slave bus
);
    localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [PW-1:0]      r_ptr, w_ptr_next;
    logic [NUM_REQ-1:0] w_rr_gnt, w_gnt, w_gnt_out;
    logic [PW-1:0]      w_rr_idx, w_rr_next, w_idx;
    logic               w_rr_any;

    logic               w_accept, w_in_range, w_sel_we;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_wdata;
    tag_t               w_tag_in, r_tag1, r_tag2;

    logic               r_mem_en;
    logic [3:0]         r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic [DW-1:0]      r_rd_hold;
    logic               w_rd_hit;
    logic [NUM_REQ-1:0] w_rd_valid, w_addr_err;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_rr_gnt),
        .o_idx      (w_rr_idx),
        .o_any      (w_rr_any),
        .o_next_ptr (w_rr_next)
    );

`ifdef BRAM_ARB_LOCK_EN
    lock_state_e   r_lk_state, w_lk_state_next;
    logic [PW-1:0] r_lk_id, w_lk_id_next;
    logic          w_lk_hold;

    // A held lock overrides round-robin and freezes the pointer; dropping lock or req releases it.
    always_comb begin
        w_lk_hold       = (r_lk_state == LK_HELD) && bus.req[r_lk_id] && bus.lock[r_lk_id];
        w_gnt           = w_rr_gnt;
        w_idx           = w_rr_idx;
        w_ptr_next      = w_rr_any ? w_rr_next : r_ptr;
        w_lk_state_next = LK_IDLE;
        w_lk_id_next    = r_lk_id;
        if (w_lk_hold) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_gnt[k] = (PW'(k) == r_lk_id);
            end
            w_idx           = r_lk_id;
            w_ptr_next      = r_ptr;
            w_lk_state_next = LK_HELD;
        end else if (w_rr_any && bus.lock[w_rr_idx]) begin
            w_lk_state_next = LK_HELD;
            w_lk_id_next    = w_rr_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lk_state <= LK_IDLE;
            r_lk_id    <= '0;
        end else begin
            r_lk_state <= w_lk_state_next;
            r_lk_id    <= w_lk_id_next;
        end
    end
`else
    always_comb begin
        w_gnt      = w_rr_gnt;
        w_idx      = w_rr_idx;
        w_ptr_next = w_rr_any ? w_rr_next : r_ptr;
    end
`endif

    always_comb begin
        w_gnt_out   = w_gnt & {NUM_REQ{rst}};
        w_accept    = |w_gnt_out;
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_addr  = bus.req_addr[k*AW +: AW];
                w_sel_we    = bus.req_we[k];
                w_sel_wdata = bus.req_wdata[k*DW +: DW];
            end
        end
        w_in_range = {1'b0, w_sel_addr} < DEPTH_L;
        w_tag_in   = '0;
        if (w_accept) begin
            w_tag_in.id    = ID_W'(w_idx);
            w_tag_in.is_rd = !w_sel_we;
            w_tag_in.err   = !w_in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_rd_hold   <= '0;
        end else begin
            r_ptr    <= w_ptr_next;
            r_mem_en <= w_accept && w_in_range;
            r_mem_we <= (w_accept && w_in_range && w_sel_we) ? WSTRB_FULL : '0;
            if (w_accept) begin
                r_mem_addr  <= word_to_byte(32'(w_sel_addr));
                r_mem_wdata <= w_sel_wdata;
            end
            r_tag1 <= w_tag_in;
            r_tag2 <= r_tag1;
            if (w_rd_hit) r_rd_hold <= bus.mem_rdata;
        end
    end

    // Stage 2 lines up with the BRAM's registered output, so read data passes straight through.
    always_comb begin
        w_rd_hit = r_tag2.is_rd && !r_tag2.err;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_rd_valid[k] = w_rd_hit && (r_tag2.id == ID_W'(k));
            w_addr_err[k] = r_tag2.err && (r_tag2.id == ID_W'(k));
        end
    end

    assign bus.gnt       = w_gnt_out;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.addr_err  = w_addr_err;
    assign bus.rd_data   = w_rd_hit ? bus.mem_rdata : r_rd_hold;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus randomized traffic against a shadow-memory model.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 801;
    localparam int SLOTS = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    bram_arbiter #(.NUM_REQ(N), .AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM with 1-cycle registered read; preload port used only while the arbiter is idle
    logic [DW-1:0] bram [0:1023];
    logic [DW-1:0] bram_q;
    logic          pl_en = 1'b0;
    logic [9:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) bram[pl_addr] <= pl_data;
        else if (bus.mem_en) begin
            if (bus.mem_we == 4'hF) bram[bus.mem_addr[11:2]] <= bus.mem_wdata;
            else bram_q <= bram[bus.mem_addr[11:2]];
        end
    end
    assign bus.mem_rdata = bram_q;

    // Reference model state
    logic [DW-1:0] shadow [0:1023];
    logic [2:0]    exp_rdv   [0:SLOTS-1];
    logic [2:0]    exp_err   [0:SLOTS-1];
    logic [DW-1:0] exp_rdata [0:SLOTS-1];
    logic          exp_en    [0:SLOTS-1];
    logic [3:0]    exp_we    [0:SLOTS-1];
    logic [31:0]   exp_addr  [0:SLOTS-1];
    logic [DW-1:0] exp_wd    [0:SLOTS-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef BRAM_ARB_LOCK_EN
        bus.lock      = '0;
`endif
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_addr[i*AW +: AW] = AW'(addr);
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = 10'(a);
        pl_data = d;
        shadow[a] = d;
        next_cycle();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        clear_req();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_req();
        bus.req = 3'b111;
        #1;
        checks++;
        if (bus.gnt !== 3'b000) begin
            errors++; $display("FAIL reset_gnt got %b want 000", bus.gnt);
        end
        checks++;
        if ({bus.rd_valid, bus.addr_err, bus.mem_en, bus.mem_we} !== 11'd0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {bus.rd_valid, bus.addr_err, bus.mem_en, bus.mem_we});
        end
        checks++;
        if ({bus.rd_data, bus.mem_addr, bus.mem_wdata} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {bus.rd_data, bus.mem_addr, bus.mem_wdata});
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        preload(5, 32'hDEADBEEF);
        set_req(0, 1'b0, 5, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b want 001", bus.gnt); end
        next_cycle();
        clear_req();
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'h0 || bus.mem_addr !== 32'h14) begin
            errors++; $display("FAIL single_mem got en=%b we=%h addr=%h want 1 0 00000014", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 3'b001 || bus.rd_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rd got %b %h want 001 deadbeef", bus.rd_valid, bus.rd_data);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 3'b000 || bus.rd_data !== 32'hDEADBEEF || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL single_hold got %b %h en=%b want 000 deadbeef 0", bus.rd_valid, bus.rd_data, bus.mem_en);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int j = 0; j < N; j++) preload(10 + j, 32'hA5A50000 | 32'(j));
        for (int j = 0; j < N; j++) set_req(j, 1'b0, 10 + j, '0);
        for (int t = 0; t < 8; t++) begin
            if (t == 6) clear_req();
            @(negedge clk);
            if (t < 6) begin
                checks++;
                if (bus.gnt !== 3'(1 << (t % 3))) begin
                    errors++; $display("FAIL fair_gnt[%0d] got %b want %b", t, bus.gnt, 3'(1 << (t % 3)));
                end
            end
            if (t >= 2) begin
                checks++;
                if (bus.rd_valid !== 3'(1 << ((t - 2) % 3)) || bus.rd_data !== (32'hA5A50000 | 32'(10 + (t - 2) % 3 - 10))) begin
                    errors++; $display("FAIL fair_rd[%0d] got %b %h want %b %h", t, bus.rd_valid, bus.rd_data,
                                       3'(1 << ((t - 2) % 3)), 32'hA5A50000 | 32'((t - 2) % 3));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(1, 1'b1, 7, 32'h12345678);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin errors++; $display("FAIL wr_gnt got %b want 010", bus.gnt); end
        next_cycle();
        clear_req();
        set_req(2, 1'b0, 7, '0);
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 4'hF || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h1C || bus.mem_wdata !== 32'h12345678 || bus.gnt !== 3'b100) begin
            errors++; $display("FAIL wr_mem got we=%h en=%b addr=%h wd=%h gnt=%b want f 1 1c 12345678 100",
                               bus.mem_we, bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.gnt);
        end
        next_cycle();
        clear_req();
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 4'h0 || bus.mem_en !== 1'b1 || bus.rd_valid !== 3'b000) begin
            errors++; $display("FAIL wr_once got we=%h en=%b rdv=%b want 0 1 000", bus.mem_we, bus.mem_en, bus.rd_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 3'b100 || bus.rd_data !== 32'h12345678) begin
            errors++; $display("FAIL raw_rd got %b %h want 100 12345678", bus.rd_valid, bus.rd_data);
        end
        next_cycle();
    endtask

    task automatic test_range();
        do_reset();
        preload(800, 32'hC0FFEE00);
        set_req(0, 1'b0, 801, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL range_gnt got %b want 001", bus.gnt); end
        next_cycle();
        clear_req();
        set_req(0, 1'b0, 800, '0);
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'h0) begin
            errors++; $display("FAIL range_en got en=%b we=%h want 0 0", bus.mem_en, bus.mem_we);
        end
        next_cycle();
        clear_req();
        @(negedge clk);
        checks++;
        if (bus.addr_err !== 3'b001 || bus.rd_valid !== 3'b000) begin
            errors++; $display("FAIL range_err got err=%b rdv=%b want 001 000", bus.addr_err, bus.rd_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.addr_err !== 3'b000 || bus.rd_valid !== 3'b001 || bus.rd_data !== 32'hC0FFEE00) begin
            errors++; $display("FAIL edge800 got err=%b rdv=%b %h want 000 001 c0ffee00", bus.addr_err, bus.rd_valid, bus.rd_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        preload(3, 32'h5555AAAA);
        set_req(1, 1'b0, 3, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt got %b want 010", bus.gnt); end
        next_cycle();
        clear_req();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.rd_valid, bus.addr_err, bus.mem_en, bus.mem_we, bus.mem_addr, bus.rd_data} !== 78'd0) begin
            errors++; $display("FAIL mid_rst got en=%b addr=%h rdv=%b want all 0", bus.mem_en, bus.mem_addr, bus.rd_valid);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (bus.rd_valid !== 3'b000 || bus.rd_data !== 32'h0) begin
                errors++; $display("FAIL mid_after[%0d] got %b %h want 000 0", t, bus.rd_valid, bus.rd_data);
            end
            next_cycle();
        end
        for (int j = 0; j < N; j++) set_req(j, 1'b0, 3, '0);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin errors++; $display("FAIL mid_ptr got %b want 001", bus.gnt); end
        next_cycle();
        clear_req();
        repeat (3) next_cycle();
    endtask

`ifdef BRAM_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        bus.lock[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 3'b001) begin errors++; $display("FAIL lock_gnt[%0d] got %b want 001", t, bus.gnt); end
            next_cycle();
        end
        bus.lock[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b010) begin errors++; $display("FAIL lock_release got %b want 010", bus.gnt); end
        next_cycle();
        clear_req();
        repeat (3) next_cycle();
    endtask
`endif

    task automatic test_random();
        bit            pend [N];
        bit            pwe  [N];
        int            paddr[N];
        logic [DW-1:0] pdat [N];
        int            m_ptr, gi, idx, c;
        logic [2:0]    exp_g;
        logic [DW-1:0] m_last;
        for (int s = 0; s < SLOTS; s++) begin
            exp_rdv[s] = '0; exp_err[s] = '0; exp_rdata[s] = '0;
            exp_en[s] = 1'b0; exp_we[s] = '0; exp_addr[s] = '0; exp_wd[s] = '0;
        end
        do_reset();
        for (int a = 0; a < 16; a++) preload(a, $urandom);
        preload(799, $urandom);
        preload(800, $urandom);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        m_ptr  = 0;
        m_last = '0;
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 10) < 6) begin
                    pend[i]  = 1'b1;
                    pwe[i]   = ($urandom % 3) == 0;
                    paddr[i] = (($urandom % 8) == 0) ? int'($urandom_range(798, 803)) : int'($urandom_range(0, 15));
                    pdat[i]  = $urandom;
                end
                bus.req[i]                = pend[i];
                bus.req_we[i]             = pwe[i];
                bus.req_addr[i*AW +: AW]  = AW'(paddr[i]);
                bus.req_wdata[i*DW +: DW] = pdat[i];
            end
            @(negedge clk);
            c     = cyc;
            exp_g = '0;
            gi    = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (gi < 0 && pend[idx]) begin gi = idx; exp_g = 3'(1 << idx); end
            end
            checks++;
            if (bus.gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt @%0d got %b want %b", t, bus.gnt, exp_g); end
            checks++;
            if (bus.mem_en !== exp_en[c] || bus.mem_we !== exp_we[c] ||
                (exp_en[c] && bus.mem_addr !== exp_addr[c]) || (exp_we[c] != 0 && bus.mem_wdata !== exp_wd[c])) begin
                errors++; $display("FAIL rnd_mem @%0d got en=%b we=%h addr=%h wd=%h want %b %h %h %h", t, bus.mem_en, bus.mem_we,
                                   bus.mem_addr, bus.mem_wdata, exp_en[c], exp_we[c], exp_addr[c], exp_wd[c]);
            end
            checks++;
            if (bus.rd_valid !== exp_rdv[c] || bus.addr_err !== exp_err[c]) begin
                errors++; $display("FAIL rnd_tag @%0d got rdv=%b err=%b want %b %b", t, bus.rd_valid, bus.addr_err, exp_rdv[c], exp_err[c]);
            end
            if (exp_rdv[c] != 0) m_last = exp_rdata[c];
            checks++;
            if (bus.rd_data !== m_last) begin errors++; $display("FAIL rnd_data @%0d got %h want %h", t, bus.rd_data, m_last); end
            if (gi >= 0) begin
                m_ptr = (gi + 1) % N;
                if (paddr[gi] < DEPTH) begin
                    exp_en[c+1]   = 1'b1;
                    exp_we[c+1]   = pwe[gi] ? 4'hF : 4'h0;
                    exp_addr[c+1] = 32'(paddr[gi]) * 4;
                    exp_wd[c+1]   = pdat[gi];
                    if (pwe[gi]) shadow[paddr[gi]] = pdat[gi];
                    else begin
                        exp_rdv[c+2]   = 3'(1 << gi);
                        exp_rdata[c+2] = shadow[paddr[gi]];
                    end
                end else exp_err[c+2] = 3'(1 << gi);
                pend[gi] = 1'b0;
            end
            next_cycle();
        end
        clear_req();
        repeat (3) next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        test_reset();
        test_single_read();
        test_fairness();
        test_write_read();
        test_range();
        test_reset_mid_read();
`ifdef BRAM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
